// File: rtl/mux_seq.sv
// mux_seq: N-channel registered mux with valid/ready output and round-robin scan.
// Define MUX_SEQ_PARITY_EN to add the registered out_par output.
module mux_seq #(
  parameter int N    = 4,
  parameter int W    = 16,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [SELW-1:0] sel,
  input  logic            mode,
  input  logic [N-1:0]    chan_mask,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_chan,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_err,
  output logic            scan_wrap
`ifdef MUX_SEQ_PARITY_EN
  ,
  output logic            out_par
`endif
);

  localparam int SELW1 = SELW + 1;
  localparam logic [SELW-1:0] LAST = SELW'(N - 1);
  localparam logic [SELW:0]   NW   = SELW1'(N);

  logic [W-1:0]    data_q, data_d;
  logic [SELW-1:0] chan_q, chan_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            wrap_q, wrap_d;
  logic            par_q, par_d;

  logic [SELW:0]   cand;
  logic [SELW-1:0] cur;
  logic [SELW-1:0] idx;
  logic [W-1:0]    pick;
  logic            found;
  logic            higher;
  logic            in_range;
  logic            mask_empty;
  logic            accept;

  // First enabled channel at or after ptr, wrapping past N-1.
  always_comb begin
    cur   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + SELW1'(k);
      if (cand >= NW) cand = cand - NW;
      if (!found && chan_mask[cand[SELW-1:0]]) begin
        found = 1'b1;
        cur   = cand[SELW-1:0];
      end
    end
  end

  always_comb begin
    higher = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (chan_mask[i] && (i > int'(cur))) higher = 1'b1;
    end
  end

  // Out-of-range selects match no channel, so pick stays zero.
  always_comb begin
    idx      = mode ? cur : sel;
    in_range = mode || (int'(sel) < N);
    pick     = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == SELW'(k)) pick = in_data[k*W +: W];
    end
  end

  assign mask_empty = mode && ~|chan_mask;
  assign in_ready   = !mask_empty && (!valid_q || out_ready);
  assign accept     = in_valid && in_ready;

  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    err_d   = err_q;
    wrap_d  = wrap_q;
    par_d   = par_q;
    if (accept) begin
      data_d  = pick;
      chan_d  = idx;
      err_d   = !in_range;
      wrap_d  = mode && !higher;
      par_d   = ^pick;
      valid_d = 1'b1;
      if (mode) ptr_d = (cur == LAST) ? '0 : cur + 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      chan_q  <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
      par_q   <= par_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;
  assign out_err   = err_q;
  assign scan_wrap = wrap_q;

`ifdef MUX_SEQ_PARITY_EN
  assign out_par = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_mux_seq.sv
// tb_mux_seq: vector table, directed corner cases and a random run against
// a queue-based reference model (N=4,W=16) plus a directed N=3,W=8 instance.
module tb_mux_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [15:0] ch [4];
  logic [63:0] in_data4;
  assign in_data4 = {ch[3], ch[2], ch[1], ch[0]};

  logic [1:0]  sel4;
  logic        mode4, iv4, ir4, ov4, or4, oe4, ow4, op4;
  logic [3:0]  mask4;
  logic [15:0] od4;
  logic [1:0]  oc4;

  logic [23:0] in_data3;
  logic [1:0]  sel3, oc3;
  logic        mode3, iv3, ir3, ov3, or3, oe3, ow3, op3;
  logic [2:0]  mask3;
  logic [7:0]  od3;

  assign in_data3 = {8'h07, 8'h22, 8'h11};

  mux_seq #(.N(4), .W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .sel(sel4),
    .mode(mode4), .chan_mask(mask4), .in_valid(iv4), .in_ready(ir4),
    .out_data(od4), .out_chan(oc4), .out_valid(ov4), .out_ready(or4),
    .out_err(oe4), .scan_wrap(ow4)
`ifdef MUX_SEQ_PARITY_EN
    , .out_par(op4)
`endif
  );

  mux_seq #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .sel(sel3),
    .mode(mode3), .chan_mask(mask3), .in_valid(iv3), .in_ready(ir3),
    .out_data(od3), .out_chan(oc3), .out_valid(ov3), .out_ready(or3),
    .out_err(oe3), .scan_wrap(ow3)
`ifdef MUX_SEQ_PARITY_EN
    , .out_par(op3)
`endif
  );

`ifndef MUX_SEQ_PARITY_EN
  assign op4 = 1'b0;
  assign op3 = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: output slot plus scan pointer.
  bit          m_valid;
  logic [15:0] m_data;
  int          m_chan, m_ptr;
  bit          m_err, m_wrap;
  logic        ir_s;

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_chan = 0;
    m_err = 0; m_wrap = 0; m_ptr = 0;
  endtask

  task automatic model_step(input logic [1:0] s, input logic md,
                            input logic [3:0] mk, input logic iv,
                            input logic ordy, output logic ir);
    int en[$];
    int cur;
    ir = !(md && mk == 0) && (!m_valid || ordy);
    if (iv && ir) begin
      if (!md) begin
        m_chan = s; m_data = ch[s]; m_err = 0; m_wrap = 0;
      end else begin
        for (int i = 0; i < 4; i++) if (mk[i]) en.push_back(i);
        cur = en[0];
        for (int j = en.size() - 1; j >= 0; j--)
          if (en[j] >= m_ptr) cur = en[j];
        m_wrap = (cur == en[en.size() - 1]);
        m_ptr  = (cur + 1) % 4;
        m_chan = cur; m_data = ch[cur]; m_err = 0;
      end
      m_valid = 1;
    end else if (ordy) begin
      m_valid = 0;
    end
  endtask

  task automatic step4(input logic [1:0] s, input logic md,
                       input logic [3:0] mk, input logic iv,
                       input logic ordy);
    logic eir;
    @(negedge clk);
    sel4 = s; mode4 = md; mask4 = mk; iv4 = iv; or4 = ordy;
    #1;
    model_step(s, md, mk, iv, ordy, eir);
    ir_s = ir4;
    chk("in_ready", ir4, eir);
    @(posedge clk);
    #1;
    chk("out_valid", ov4, m_valid);
    if (m_valid) begin
      chk("out_data", od4, m_data);
      chk("out_chan", oc4, m_chan);
      chk("out_err", oe4, m_err);
      chk("scan_wrap", ow4, m_wrap);
`ifdef MUX_SEQ_PARITY_EN
      chk("out_par", op4, ^m_data);
`endif
    end
  endtask

  task automatic step3(input logic [1:0] s, input logic md,
                       input logic [2:0] mk);
    @(negedge clk);
    sel3 = s; mode3 = md; mask3 = mk; iv3 = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic        md;
    logic [3:0]  mk;
    logic        iv;
    logic        ordy;
    logic        eir;
    logic        ev;
    logic [15:0] ed;
    logic [1:0]  ec;
    logic        ew;
  } vec_t;

  function automatic vec_t mkv(logic [1:0] s, logic md, logic [3:0] mk,
                               logic iv, logic ordy, logic eir, logic ev,
                               logic [15:0] ed, logic [1:0] ec, logic ew);
    vec_t v;
    v.sel = s; v.md = md; v.mk = mk; v.iv = iv; v.ordy = ordy;
    v.eir = eir; v.ev = ev; v.ed = ed; v.ec = ec; v.ew = ew;
    return v;
  endfunction

  vec_t tbl [17];

  initial begin
    tbl[0]  = mkv(3, 0, 0, 1, 1, 1, 1, 16'h7FFF, 3, 0);
    tbl[1]  = mkv(2, 0, 0, 1, 1, 1, 1, 16'hBFFF, 2, 0);
    tbl[2]  = mkv(1, 0, 0, 1, 1, 1, 1, 16'hDFFF, 1, 0);
    tbl[3]  = mkv(0, 0, 0, 1, 0, 0, 1, 16'hDFFF, 1, 0);
    tbl[4]  = mkv(0, 0, 0, 1, 0, 0, 1, 16'hDFFF, 1, 0);
    tbl[5]  = mkv(0, 0, 0, 1, 0, 0, 1, 16'hDFFF, 1, 0);
    tbl[6]  = mkv(0, 0, 0, 1, 1, 1, 1, 16'hFFFF, 0, 0);
    tbl[7]  = mkv(0, 1, 4'b1011, 1, 1, 1, 1, 16'hFFFF, 0, 0);
    tbl[8]  = mkv(0, 1, 4'b1011, 1, 1, 1, 1, 16'hDFFF, 1, 0);
    tbl[9]  = mkv(0, 1, 4'b1011, 1, 1, 1, 1, 16'h7FFF, 3, 1);
    tbl[10] = mkv(0, 1, 4'b1011, 1, 1, 1, 1, 16'hFFFF, 0, 0);
    tbl[11] = mkv(0, 1, 4'b1011, 1, 1, 1, 1, 16'hDFFF, 1, 0);
    tbl[12] = mkv(0, 1, 4'b1011, 1, 1, 1, 1, 16'h7FFF, 3, 1);
    tbl[13] = mkv(0, 1, 4'b0000, 1, 1, 0, 0, 16'h0000, 0, 0);
    tbl[14] = mkv(0, 1, 4'b0000, 1, 1, 0, 0, 16'h0000, 0, 0);
    tbl[15] = mkv(0, 1, 4'b0100, 1, 1, 1, 1, 16'hBFFF, 2, 1);
    tbl[16] = mkv(0, 1, 4'b0100, 1, 1, 1, 1, 16'hBFFF, 2, 1);

    rst_n = 1'b0;
    sel4 = 0; mode4 = 0; mask4 = 0; iv4 = 0; or4 = 1;
    sel3 = 0; mode3 = 0; mask3 = 0; iv3 = 0; or3 = 1;
    ch[0] = 16'hFFFF; ch[1] = 16'hDFFF;
    ch[2] = 16'hBFFF; ch[3] = 16'h7FFF;
    model_reset();
    #12;
    chk("rst_valid", ov4, 0);
    chk("rst_data", od4, 0);
    chk("rst_chan", oc4, 0);
    chk("rst_err", oe4, 0);
    chk("rst_wrap", ow4, 0);
    chk("rst_par", op4, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step4(tbl[i].sel, tbl[i].md, tbl[i].mk, tbl[i].iv, tbl[i].ordy);
      chk("t_ir", ir_s, tbl[i].eir);
      chk("t_valid", ov4, tbl[i].ev);
      if (tbl[i].ev) begin
        chk("t_data", od4, tbl[i].ed);
        chk("t_chan", oc4, tbl[i].ec);
        chk("t_wrap", ow4, tbl[i].ew);
      end
    end

    // Stall with ptr=3, then reset between edges.
    step4(0, 1, 4'b0100, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", ov4, 0);
    chk("arst_data", od4, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step4(0, 1, 4'b1011, 1, 1);
    chk("arst_scan_chan", oc4, 0);

    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < 4; c++) ch[c] = 16'($urandom);
      step4(2'($urandom), 1'($urandom), 4'($urandom),
            ($urandom_range(3) != 0), ($urandom_range(9) < 7));
    end
    step4(0, 0, 0, 0, 1);
    iv4 = 1'b0;

    step3(3, 0, 0);
    chk("n3_oor_valid", ov3, 1);
    chk("n3_oor_data", od3, 0);
    chk("n3_oor_err", oe3, 1);
    chk("n3_oor_chan", oc3, 3);
    step3(2, 0, 0);
    chk("n3_s2_data", od3, 8'h07);
    chk("n3_s2_err", oe3, 0);
    chk("n3_s2_chan", oc3, 2);
`ifdef MUX_SEQ_PARITY_EN
    chk("n3_s2_par", op3, 1);
`endif
    step3(0, 1, 3'b111);
    chk("n3_sc0_chan", oc3, 0);
    chk("n3_sc0_wrap", ow3, 0);
    step3(0, 1, 3'b111);
    chk("n3_sc1_chan", oc3, 1);
    step3(0, 1, 3'b111);
    chk("n3_sc2_chan", oc3, 2);
    chk("n3_sc2_wrap", ow3, 1);
    chk("n3_sc2_data", od3, 8'h07);
    step3(0, 1, 3'b111);
    chk("n3_sc3_chan", oc3, 0);
    chk("n3_sc3_data", od3, 8'h11);
    step3(0, 1, 3'b101);
    chk("n3_m5_chan", oc3, 2);
    chk("n3_m5_wrap", ow3, 1);
    step3(0, 1, 3'b101);
    chk("n3_m5b_chan", oc3, 0);
    chk("n3_m5b_wrap", ow3, 0);
    iv3 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
